// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM states and the default operand width.
package ex_pkg;

   localparam int EX_DATA_W = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MADD  = 3'b100,
      OP_MSUB  = 3'b101,
      OP_MTHI  = 3'b110,
      OP_MTLO  = 3'b111
   } opT;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } stateT;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: a shift-add multiply step (LSB first) or a
// restoring-divide step (MSB first) on the {hi, lo} working pair.
module muldiv_step
   import ex_pkg::*;
#(
   parameter int DATA_W = EX_DATA_W
) (
   input  logic              isDiv,
   input  logic [DATA_W-1:0] operand,
   input  logic [DATA_W-1:0] hiIn,
   input  logic [DATA_W-1:0] loIn,
   output logic [DATA_W-1:0] hiOut,
   output logic [DATA_W-1:0] loOut
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   always_comb begin
      sum     = {1'b0, hiIn} + (loIn[0] ? {1'b0, operand} : '0);
      shifted = {hiIn, loIn[DATA_W-1]};
      // The partial remainder stays below 2*divisor, so bit DATA_W of the
      // difference is set exactly when the trial subtraction borrows.
      diff    = shifted - {1'b0, operand};
      if (isDiv) begin
         if (diff[DATA_W]) begin
            hiOut = shifted[DATA_W-1:0];
            loOut = {loIn[DATA_W-2:0], 1'b0};
         end else begin
            hiOut = diff[DATA_W-1:0];
            loOut = {loIn[DATA_W-2:0], 1'b1};
         end
      end else begin
         hiOut = sum[DATA_W:1];
         loOut = {sum[0], loIn[DATA_W-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO, a start/busy/done
// handshake, MADD/MSUB accumulate, divide-by-zero flag and flush.
module ex_muldiv_unit
   import ex_pkg::*;
#(
   parameter int DATA_W         = EX_DATA_W,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [2:0]        Op,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              HiLoRead,
   input  logic              Flush,
   output logic [DATA_W-1:0] Hi,
   output logic [DATA_W-1:0] Lo,
   output logic              Busy,
   output logic              Done,
   output logic              DivZero,
   output logic              Stall
);

   localparam int N     = DATA_W / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   stateT               state, nextState;
   logic [CNT_W-1:0]    count;
   opT                  opReg;
   logic                signA, signB, bZero, isDiv;
   logic [DATA_W-1:0]   hiArch, loArch, workHi, workLo, operand, aReg;
   logic                mdStart, mvStart;
   logic                opIsDiv, opSigned, inSignA, inSignB;
   logic [DATA_W-1:0]   magA, magB, resHi, resLo;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   chainHi [BITS_PER_CYCLE+1];
   logic [DATA_W-1:0]   chainLo [BITS_PER_CYCLE+1];

   assign Hi    = hiArch;
   assign Lo    = loArch;
   assign Busy  = (state != IDLE);
   assign Stall = Busy & (Start | HiLoRead);
   assign isDiv = (opReg == OP_DIV) || (opReg == OP_DIVU);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      // NOTE: every output of this block is given a default before the case
      // so that no path leaves one unassigned and infers a latch.
      nextState = state;
      mdStart   = 1'b0;
      mvStart   = 1'b0;
      case (state)
         IDLE: if (Start && !Flush) begin
            if (Op == OP_MTHI || Op == OP_MTLO) begin
               mvStart = 1'b1;
            end else begin
               mdStart   = 1'b1;
               nextState = RUN;
            end
         end
         RUN:     if (count == '0) nextState = FIX;
         FIX:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
      if (Flush) nextState = IDLE;
   end

   // Signed ops iterate on magnitudes; signs are reapplied in FIX.
   always_comb begin
      opIsDiv  = (Op == OP_DIV) || (Op == OP_DIVU);
      opSigned = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
      inSignA  = opSigned & A[DATA_W-1];
      inSignB  = opSigned & B[DATA_W-1];
      magA     = inSignA ? -A : A;
      magB     = inSignB ? -B : B;
   end

   assign chainHi[0] = workHi;
   assign chainLo[0] = workLo;

   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : gStep
      muldiv_step #(.DATA_W(DATA_W)) uStep (
         .isDiv  (isDiv),
         .operand(operand),
         .hiIn   (chainHi[g]),
         .loIn   (chainLo[g]),
         .hiOut  (chainHi[g+1]),
         .loOut  (chainLo[g+1])
      );
   end

   always_comb begin
      prod  = (signA ^ signB) ? -{workHi, workLo} : {workHi, workLo};
      resHi = prod[2*DATA_W-1:DATA_W];
      resLo = prod[DATA_W-1:0];
      case (opReg)
         OP_MADD: {resHi, resLo} = {hiArch, loArch} + prod;
         OP_MSUB: {resHi, resLo} = {hiArch, loArch} - prod;
         OP_DIV, OP_DIVU: begin
            resLo = (signA ^ signB) ? -workLo : workLo;
            resHi = signA ? -workHi : workHi;
            if (bZero) begin
               resHi = aReg;
               resLo = '1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hiArch  <= '0;
         loArch  <= '0;
         workHi  <= '0;
         workLo  <= '0;
         operand <= '0;
         aReg    <= '0;
         opReg   <= OP_MULT;
         signA   <= 1'b0;
         signB   <= 1'b0;
         bZero   <= 1'b0;
         count   <= '0;
         Done    <= 1'b0;
         DivZero <= 1'b0;
      end else begin
         Done    <= 1'b0;
         DivZero <= 1'b0;
         if (mvStart) begin
            if (Op == OP_MTHI) hiArch <= A;
            else               loArch <= A;
            Done <= 1'b1;
         end
         if (mdStart) begin
            opReg   <= opT'(Op);
            signA   <= inSignA;
            signB   <= inSignB;
            aReg    <= A;
            bZero   <= (B == '0);
            operand <= opIsDiv ? magB : magA;
            workHi  <= '0;
            workLo  <= opIsDiv ? magA : magB;
            count   <= CNT_W'(N - 1);
         end else if (state == RUN && !Flush) begin
            workHi <= chainHi[BITS_PER_CYCLE];
            workLo <= chainLo[BITS_PER_CYCLE];
            if (count != '0) count <= count - CNT_W'(1);
         end
         if (state == FIX && !Flush) begin
            hiArch  <= resHi;
            loArch  <= resLo;
            Done    <= 1'b1;
            DivZero <= isDiv & bZero;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench: two unit instances (1 and 4 bits per cycle) share one
// directed stimulus and are compared every cycle against a behavioural model.
module tb_ex_muldiv_unit;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] a = 32'h0, b = 32'h0;
   logic        hiLoRead = 1'b0, flush = 1'b0;

   logic [31:0] hi1, lo1, hi4, lo4;
   logic        busy1, done1, dz1, stall1;
   logic        busy4, done4, dz4, stall4;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.DATA_W(32), .BITS_PER_CYCLE(1)) dut1 (
      .Clock(clk), .Reset(rst), .Start(start), .Op(op), .A(a), .B(b),
      .HiLoRead(hiLoRead), .Flush(flush), .Hi(hi1), .Lo(lo1), .Busy(busy1),
      .Done(done1), .DivZero(dz1), .Stall(stall1)
   );

   ex_muldiv_unit #(.DATA_W(32), .BITS_PER_CYCLE(4)) dut4 (
      .Clock(clk), .Reset(rst), .Start(start), .Op(op), .A(a), .B(b),
      .HiLoRead(hiLoRead), .Flush(flush), .Hi(hi4), .Lo(lo4), .Busy(busy4),
      .Done(done4), .DivZero(dz4), .Stall(stall4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: results come from plain arithmetic at issue time and
   // are released after the issue-to-update latency.
   typedef struct {
      logic [31:0] hi, lo, pHi, pLo;
      int          remain;
      bit          pDz, done, dz;
   } modelT;

   modelT m1 = '{default: 0};
   modelT m4 = '{default: 0};

   function automatic void calc(input logic [2:0] o, input logic [31:0] x, y, hiNow, loNow,
                                output logic [31:0] rh, rl, output bit z);
      logic [63:0] r;
      longint      sp;
      sp = longint'(signed'(x)) * longint'(signed'(y));
      r  = {hiNow, loNow};
      z  = 1'b0;
      case (o)
         OP_MULT:  r = sp;
         OP_MULTU: r = {32'h0, x} * {32'h0, y};
         OP_MADD:  r = r + sp;
         OP_MSUB:  r = r - sp;
         OP_DIV, OP_DIVU: begin
            if (y == 32'h0) begin
               r = {x, 32'hFFFF_FFFF};
               z = 1'b1;
            end else if (o == OP_DIVU) begin
               r = {x % y, x / y};
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               r = {32'h0, x};
            end else begin
               int q, rm;
               q  = signed'(x) / signed'(y);
               rm = signed'(x) % signed'(y);
               r  = {rm, q};
            end
         end
         default: ;
      endcase
      rh = r[63:32];
      rl = r[31:0];
   endfunction

   function automatic modelT modelStep(input modelT m, input int lat);
      m.done = 1'b0;
      m.dz   = 1'b0;
      if (m.remain > 0) begin
         if (flush) begin
            m.remain = 0;
         end else begin
            m.remain = m.remain - 1;
            if (m.remain == 0) begin
               m.hi   = m.pHi;
               m.lo   = m.pLo;
               m.done = 1'b1;
               m.dz   = m.pDz;
            end
         end
      end else if (start && !flush) begin
         if (op == OP_MTHI) begin
            m.hi = a; m.done = 1'b1;
         end else if (op == OP_MTLO) begin
            m.lo = a; m.done = 1'b1;
         end else begin
            calc(op, a, b, m.hi, m.lo, m.pHi, m.pLo, m.pDz);
            m.remain = lat;
         end
      end
      return m;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m1 = '{default: 0};
         m4 = '{default: 0};
      end else begin
         m1 = modelStep(m1, 33);
         m4 = modelStep(m4, 9);
      end
   end

   task automatic cmp(input string t, input logic [31:0] h, l, input logic bz, dn, z, st,
                      input modelT m);
      logic mb;
      mb = (m.remain > 0);
      check({t, ".Hi"}, h, m.hi);
      check({t, ".Lo"}, l, m.lo);
      check({t, ".Busy"}, 32'(bz), 32'(mb));
      check({t, ".Done"}, 32'(dn), 32'(m.done));
      check({t, ".DivZero"}, 32'(z), 32'(m.dz));
      check({t, ".Stall"}, 32'(st), 32'(mb & (start | hiLoRead)));
   endtask

   always begin
      @(negedge clk);
      #1;
      cmp("bpc1", hi1, lo1, busy1, done1, dz1, stall1, m1);
      cmp("bpc4", hi4, lo4, busy4, done4, dz4, stall4, m4);
   end

   // Issue one op, then wait until both instances are idle; returns at the
   // negedge where the slower instance shows Done.
   task automatic runOp(input logic [2:0] o, input logic [31:0] x, y, output int c1, c4);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      c1 = 0;
      c4 = 0;
      for (int i = 0; i < 100; i++) begin
         if (!busy1 && !busy4) break;
         if (busy1) c1++;
         if (busy4) c4++;
         @(negedge clk);
      end
      if (busy1 || busy4) check("runOp.timeout", 32'(busy1 | busy4), 32'h0);
   endtask

   initial begin
      int c1, c4;
      repeat (2) @(negedge clk);
      check("reset.Hi", hi1, 32'h0);
      check("reset.Lo", lo1, 32'h0);
      check("reset.Busy", 32'(busy1), 32'h0);
      check("reset.Done", 32'(done1), 32'h0);
      rst = 1'b0;

      runOp(OP_MULT, 32'hFFFF_FFFD, 32'd7, c1, c4);
      check("mult.latency1", c1, 33);
      check("mult.latency4", c4, 9);
      check("mult.Hi", hi1, 32'hFFFF_FFFF);
      check("mult.Lo", lo1, 32'hFFFF_FFEB);
      check("mult.Hi4", hi4, 32'hFFFF_FFFF);
      check("mult.Lo4", lo4, 32'hFFFF_FFEB);
      check("mult.Done", 32'(done1), 32'h1);
      @(negedge clk);
      check("mult.donePulse", 32'(done1), 32'h0);

      runOp(OP_MULTU, 32'hFFFF_FFFD, 32'd7, c1, c4);
      check("multu.Hi", hi1, 32'h0000_0006);
      check("multu.Lo", lo1, 32'hFFFF_FFEB);
      check("multu.Hi4", hi4, 32'h0000_0006);

      runOp(OP_DIVU, 32'd100, 32'd7, c1, c4);
      check("divu.Lo", lo1, 32'd14);
      check("divu.Hi", hi1, 32'd2);
      runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, c1, c4);
      check("div.Lo", lo1, 32'hFFFF_FFFD);
      check("div.Hi", hi1, 32'hFFFF_FFFF);
      runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c1, c4);
      check("divOvf.Lo", lo1, 32'h8000_0000);
      check("divOvf.Hi", hi1, 32'h0);
      check("divOvf.Lo4", lo4, 32'h8000_0000);

      runOp(OP_DIV, 32'h1234, 32'h0, c1, c4);
      check("div0.latency", c1, 33);
      check("div0.Hi", hi1, 32'h1234);
      check("div0.Lo", lo1, 32'hFFFF_FFFF);
      check("div0.DivZero", 32'(dz1), 32'h1);
      check("div0.Done", 32'(done1), 32'h1);
      @(negedge clk);
      check("div0.pulse", 32'(dz1), 32'h0);

      // MTHI and HiLoRead presented while a MULT is in flight
      start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      hiLoRead = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'h0000_AAAA;
      #1;
      check("stall.Stall", 32'(stall1), 32'h1);
      check("stall.HiHeld", hi1, 32'h1234);
      for (int i = 0; i < 100 && busy1; i++) @(negedge clk);
      if (busy1) check("stall.timeout", 32'(busy1), 32'h0);
      check("stall.mulDone", 32'(done1), 32'h1);
      check("stall.mulLo", lo1, 32'd30);
      @(negedge clk);
      start = 1'b0; hiLoRead = 1'b0;
      check("mthi.Hi", hi1, 32'h0000_AAAA);
      check("mthi.Lo", lo1, 32'd30);
      check("mthi.Done", 32'(done1), 32'h1);
      check("mthi.Hi4", hi4, 32'h0000_AAAA);

      runOp(OP_MTLO, 32'hFFFF_FFFF, 32'h0, c1, c4);
      runOp(OP_MTHI, 32'h0, 32'h0, c1, c4);
      check("preload.Hi", hi1, 32'h0);
      check("preload.Lo", lo1, 32'hFFFF_FFFF);
      runOp(OP_MADD, 32'd1, 32'd1, c1, c4);
      check("madd.Hi", hi1, 32'h1);
      check("madd.Lo", lo1, 32'h0);
      check("madd.Hi4", hi4, 32'h1);
      runOp(OP_MSUB, 32'd1, 32'd1, c1, c4);
      check("msub.Hi", hi1, 32'h0);
      check("msub.Lo", lo1, 32'hFFFF_FFFF);
      check("msub.Lo4", lo4, 32'hFFFF_FFFF);

      // Flush ten cycles into a MULT
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush.Busy", 32'(busy1), 32'h0);
      check("flush.Hi", hi1, 32'h0);
      check("flush.Lo", lo1, 32'hFFFF_FFFF);
      check("flush.Done", 32'(done1), 32'h0);

      // Start and Flush together: the Start is dropped
      start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flushStart.Busy1", 32'(busy1), 32'h0);
      check("flushStart.Busy4", 32'(busy4), 32'h0);

      // Asynchronous reset in the middle of a DIV
      runOp(OP_MTHI, 32'h5555, 32'h0, c1, c4);
      @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rstMid.Hi", hi1, 32'h0);
      check("rstMid.Lo", lo1, 32'h0);
      check("rstMid.Busy", 32'(busy1), 32'h0);
      check("rstMid.Busy4", 32'(busy4), 32'h0);
      check("rstMid.Lo4", lo4, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rstMid.noDone", 32'(done1), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
